// File: rtl/alu_dispatch.sv
// alu_dispatch: decodes RV32I ALU instructions into ALUSel/in_a/in_b behind a two-entry skid buffer.
// Optional ALU_DISPATCH_COUNT_EN adds a wrapping issue_count of legal instructions delivered.
module alu_dispatch #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALUSel,
    output logic [WIDTH-1:0] in_a,
    output logic [WIDTH-1:0] in_b,
    output logic             illegal
`ifdef ALU_DISPATCH_COUNT_EN
    ,
    output logic [31:0]      issue_count
`endif
);
    localparam int EW = 2 * WIDTH + 5;
    logic             r_type, i_type, shift, bad;
    logic [3:0]       sel;
    logic [WIDTH-1:0] src, op_b;
    logic [EW-1:0]    dec, out_q, skid_q;
    logic             skid_valid, acc, drn;
    always_comb begin
        r_type = opcode == 7'b0110011;
        i_type = opcode == 7'b0010011;
        shift  = funct3 == 3'b001 || funct3 == 3'b101;
        bad    = !(r_type || i_type) ||
                 (r_type && funct7_5 && funct3 != 3'b000 && funct3 != 3'b101) ||
                 (i_type && funct7_5 && funct3 == 3'b001);
        sel    = funct3 == 3'b000 ? {3'b000, r_type && funct7_5} :
                 funct3 == 3'b001 ? 4'd2 :
                 funct3 == 3'b010 ? 4'd3 :
                 funct3 == 3'b011 ? 4'd4 :
                 funct3 == 3'b100 ? 4'd5 :
                 funct3 == 3'b101 ? (funct7_5 ? 4'd7 : 4'd6) :
                 funct3 == 3'b110 ? 4'd8 : 4'd9;
        src    = r_type ? rs2_data : imm;
        // Shift amounts are masked so the ALU never sees a count >= WIDTH
        op_b   = shift ? {{(WIDTH-SHW){1'b0}}, src[SHW-1:0]} : src;
        dec    = bad ? {1'b1, {(EW-1){1'b0}}} : {1'b0, sel, rs1_data, op_b};
    end
    assign in_ready = !skid_valid;
    assign acc = in_valid && in_ready;
    assign drn = out_valid && out_ready;
    assign {illegal, ALUSel, in_a, in_b} = out_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_q      <= '0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
        end else if (drn || !out_valid) begin
            // Skid content always goes first to preserve ordering
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (acc) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (acc) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end
`ifdef ALU_DISPATCH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issue_count <= '0;
        else if (drn && !illegal)
            issue_count <= issue_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed self-checking bench for alu_dispatch.
module tb_alu_dispatch;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, funct7_5, out_valid, out_ready, illegal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm, in_a, in_b;
    logic [3:0]  ALUSel;
    int          checks = 0;
    int          errors = 0;
`ifdef ALU_DISPATCH_COUNT_EN
    logic [31:0] issue_count;
`endif

    alu_dispatch dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .ALUSel(ALUSel),
        .in_a(in_a), .in_b(in_b), .illegal(illegal)
`ifdef ALU_DISPATCH_COUNT_EN
        , .issue_count(issue_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        in_valid = 1'b1; opcode = op; funct3 = f3; funct7_5 = f7;
        rs1_data = a; rs2_data = b; imm = im;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] sel, input logic [31:0] a,
                              input logic [31:0] b, input logic ill);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_sel"}, {28'd0, ALUSel}, {28'd0, sel});
        chk({tag, "_a"}, in_a, a);
        chk({tag, "_b"}, in_b, b);
        chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, ill});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct3 = '0; funct7_5 = 1'b0; rs1_data = '0; rs2_data = '0; imm = '0;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_sel", {28'd0, ALUSel}, 32'd0);
        chk("rst_a", in_a, 32'd0);
        chk("rst_b", in_b, 32'd0);
        chk("rst_ill", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Streaming with out_ready high: one instruction per cycle
        out_ready = 1'b1;
        drive(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0);
        tick();
        expect_out("sub", 4'd1, 32'd10, 32'd3, 1'b0);
        drive(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0425);
        tick();
        expect_out("srai", 4'd7, 32'h8000_0000, 32'd5, 1'b0);
        drive(7'b0110011, 3'b001, 1'b0, 32'd1, 32'h23, 32'd0);
        tick();
        expect_out("sll", 4'd2, 32'd1, 32'd3, 1'b0);
        drive(7'b0110011, 3'b101, 1'b0, 32'hF0, 32'hFFFF_FFE4, 32'd0);
        tick();
        expect_out("srl", 4'd6, 32'hF0, 32'd4, 1'b0);
        drive(7'b0010011, 3'b000, 1'b1, 32'd2, 32'd0, 32'hFFFF_FFFF);
        tick();
        expect_out("addi_f7", 4'd0, 32'd2, 32'hFFFF_FFFF, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        // Back-pressure: A to output, B to skid, C held
        out_ready = 1'b0;
        drive(7'b0010011, 3'b000, 1'b0, 32'd1, 32'd0, 32'd100);
        tick();
        chk("bp_ready_a", {31'd0, in_ready}, 32'd1);
        drive(7'b0110011, 3'b100, 1'b0, 32'd5, 32'd6, 32'd0);
        tick();
        chk("bp_ready_b", {31'd0, in_ready}, 32'd0);
        expect_out("bp_holdA1", 4'd0, 32'd1, 32'd100, 1'b0);
        drive(7'b0010011, 3'b111, 1'b0, 32'd7, 32'd0, 32'hF);
        tick();
        chk("bp_ready_c", {31'd0, in_ready}, 32'd0);
        expect_out("bp_holdA2", 4'd0, 32'd1, 32'd100, 1'b0);
        out_ready = 1'b1;
        tick();
        expect_out("bp_B", 4'd5, 32'd5, 32'd6, 1'b0);
        chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
        tick();
        expect_out("bp_C", 4'd9, 32'd7, 32'hF, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Illegal combinations are delivered zeroed with the flag set
        drive(7'b0000011, 3'b000, 1'b0, 32'd9, 32'd8, 32'd7);
        tick();
        expect_out("ill_op", 4'd0, 32'd0, 32'd0, 1'b1);
        drive(7'b0110011, 3'b010, 1'b1, 32'd3, 32'd4, 32'd0);
        tick();
        expect_out("ill_rf7", 4'd0, 32'd0, 32'd0, 1'b1);
        drive(7'b0010011, 3'b001, 1'b1, 32'd3, 32'd0, 32'h405);
        tick();
        expect_out("ill_slli", 4'd0, 32'd0, 32'd0, 1'b1);
        drive(7'b0010011, 3'b011, 1'b0, 32'd6, 32'd0, 32'h7);
        tick();
        expect_out("sltiu", 4'd4, 32'd6, 32'd7, 1'b0);
        in_valid = 1'b0;
        tick();

        // Reset while skid is full discards both entries
        out_ready = 1'b0;
        drive(7'b0110011, 3'b110, 1'b0, 32'd1, 32'd2, 32'd0);
        tick();
        drive(7'b0110011, 3'b011, 1'b0, 32'd3, 32'd4, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("mid_skid_full", {31'd0, in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_a", in_a, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst1", {31'd0, out_valid}, 32'd0);
        tick();
        chk("post_rst2", {31'd0, out_valid}, 32'd0);

`ifdef ALU_DISPATCH_COUNT_EN
        drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0);
        tick();
        drive(7'b0000000, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0);
        tick();
        drive(7'b0010011, 3'b110, 1'b0, 32'd1, 32'd1, 32'd1);
        tick();
        drive(7'b0010011, 3'b010, 1'b0, 32'd1, 32'd1, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("issue_count", issue_count, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
